// File: rtl/iter_mul_div_unit.sv
// iter_mul_div_unit: multi-cycle multiply/divide unit producing a HI/LO pair.
//   Multiply: radix-2 Booth, one step per clock.
//   Divide:   non-restoring on magnitudes, one step per clock, sign fix-up at the end.
// Ports:
//   Clk, Clear        clock, asynchronous active-high reset
//   start, op         request (sampled in IDLE/DONE), 1 = multiply, 0 = divide
//   is_signed         two's-complement operands when 1
//   a, b              multiplicand/dividend, multiplier/divisor
//   busy, done        busy in RUN/FIX, done is a one-cycle pulse in DONE
//   result_lo/hi      product low/high, or quotient/remainder
//   div_by_zero       set with done for a divide by zero, cleared on next accept
module iter_mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH:0]   acc, m;       // accumulator and extended M
  logic [WIDTH-1:0] q;
  logic             q_m1;         // Booth q-1
  logic [CNT_W-1:0] cnt;
  logic             op_r, uns_r, neg_q, neg_r, dbz_r;

  logic accept, dbz_req, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign accept  = start && (state == S_IDLE || state == S_DONE);
  assign dbz_req = !op && (b == '0);
  assign a_neg   = is_signed && a[WIDTH-1];
  assign b_neg   = is_signed && b[WIDTH-1];
  assign abs_a   = a_neg ? -a : a;  // most-negative stays as 2^(W-1), a valid magnitude
  assign abs_b   = b_neg ? -b : b;

  assign busy = (state == S_RUN) || (state == S_FIX);
  assign done = (state == S_DONE);

  // ---------------- FSM ----------------
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (!start)       state_nxt = S_IDLE;
        else if (dbz_req) state_nxt = S_FIX;   // no iterations, results written in FIX
        else              state_nxt = S_RUN;
      end
      S_RUN:   if (cnt == CNT_W'(1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- iteration step ----------------
  logic [WIDTH:0]   mul_sum, div_sh, div_sum;
  logic [WIDTH-1:0] rem, quo, prod_hi;

  always_comb begin
    mul_sum = acc;
    case ({q[0], q_m1})
      2'b01:   mul_sum = acc + m;
      2'b10:   mul_sum = acc - m;
      default: mul_sum = acc;
    endcase
    // Sign of A before the shift picks add/sub; W+1-bit wraparound is harmless
    // because the post-add value always lies in [-M, M).
    div_sh  = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_sum = acc[WIDTH] ? div_sh + m : div_sh - m;
    // Remainder restore, only the low W bits matter.
    rem     = acc[WIDTH-1:0] + (acc[WIDTH] ? m[WIDTH-1:0] : '0);
    quo     = q;
    // W Booth steps treat the multiplier as signed; for an unsigned multiplier
    // with MSB set, add M at weight 2^W (the final Booth pair {0, q-1=1}).
    prod_hi = acc[WIDTH-1:0] + ((uns_r && q_m1) ? m[WIDTH-1:0] : '0);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      acc <= '0; m <= '0; q <= '0; q_m1 <= 1'b0; cnt <= '0;
      op_r <= 1'b0; uns_r <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; dbz_r <= 1'b0;
      result_lo <= '0; result_hi <= '0; div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          op_r        <= op;
          uns_r       <= !is_signed;
          neg_q       <= a_neg ^ b_neg;
          neg_r       <= a_neg;
          dbz_r       <= dbz_req;
          cnt         <= CNT_W'(WIDTH);
          acc         <= '0;
          q_m1        <= 1'b0;
          div_by_zero <= 1'b0;
          if (op) begin
            m <= {a_neg, a};
            q <= b;
          end else begin
            m <= {1'b0, abs_b};
            q <= dbz_req ? a : abs_a;   // raw dividend kept for the div-by-zero result
          end
        end
        S_RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (op_r) begin
            acc  <= {mul_sum[WIDTH], mul_sum[WIDTH:1]};
            q    <= {mul_sum[0], q[WIDTH-1:1]};
            q_m1 <= q[0];
          end else begin
            acc <= div_sum;
            q   <= {q[WIDTH-2:0], ~div_sum[WIDTH]};
          end
        end
        S_FIX: begin
          if (dbz_r) begin
            result_lo   <= '1;
            result_hi   <= q;
            div_by_zero <= 1'b1;
          end else if (op_r) begin
            result_lo <= q;
            result_hi <= prod_hi;
          end else begin
            result_lo <= neg_q ? -quo : quo;
            result_hi <= neg_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_mul_div_unit.sv
module tb_iter_mul_div_unit;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Clear = 1'b1;
  logic         start = 1'b0, op = 1'b0, is_signed = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_lo, result_hi;

  int n_chk = 0, n_pass = 0;

  iter_mul_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Clear(Clear), .start(start), .op(op), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .result_lo(result_lo),
    .result_hi(result_hi), .div_by_zero(div_by_zero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Present a request, let one edge accept it, drop start; returns #1 after the accept edge.
  task automatic issue(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; is_signed = s; a = x; b = y; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen (sampled #1 after each edge), bounded.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk); #1;
      n++;
      if (done) return;
    end
    chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  int n, dn;

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lo", result_lo, 0);
    chk("rst_hi", result_hi, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge Clk); Clear = 1'b0;

    // signed multiply 7 * -3 = -21
    issue(1, 1, 32'd7, 32'hFFFF_FFFD);
    chk("smul_busy", busy, 1);
    wait_done("smul", n);
    chk("smul_lat", n, 33);
    chk("smul_hi", result_hi, 32'hFFFF_FFFF);
    chk("smul_lo", result_lo, 32'hFFFF_FFEB);
    chk("smul_busy_done", busy, 0);

    // unsigned multiply, multiplier MSB set
    issue(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("umul", n);
    chk("umul_hi", result_hi, 32'hFFFF_FFFE);
    chk("umul_lo", result_lo, 32'h0000_0001);

    // signed divide -7 / 2 -> q=-3, r=-1
    issue(0, 1, 32'hFFFF_FFF9, 32'd2);
    wait_done("sdiv", n);
    chk("sdiv_lat", n, 33);
    chk("sdiv_lo", result_lo, 32'hFFFF_FFFD);
    chk("sdiv_hi", result_hi, 32'hFFFF_FFFF);
    chk("sdiv_dbz", div_by_zero, 0);

    // unsigned 100 / 7
    issue(0, 0, 32'd100, 32'd7);
    wait_done("udiv", n);
    chk("udiv_lo", result_lo, 32'd14);
    chk("udiv_hi", result_hi, 32'd2);

    // divide by zero
    issue(0, 0, 32'd100, 32'd0);
    wait_done("dbz", n);
    chk("dbz_lat", n, 1);
    chk("dbz_lo", result_lo, 32'hFFFF_FFFF);
    chk("dbz_hi", result_hi, 32'd100);
    chk("dbz_flag", div_by_zero, 1);

    // signed overflow: most-negative / -1, flag cleared at accept
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_dbz_clr", div_by_zero, 0);
    wait_done("ovf", n);
    chk("ovf_lo", result_lo, 32'h8000_0000);
    chk("ovf_hi", result_hi, 32'd0);
    chk("ovf_dbz", div_by_zero, 0);

    // start during RUN is ignored: 5*9 while a 1*1 request is pulsed at cycle 10
    issue(1, 0, 32'd5, 32'd9);
    repeat (9) @(posedge Clk);
    #1; op = 1'b1; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
    dn = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge Clk); #1;
      if (done) begin
        dn++;
        chk("ign_lo", result_lo, 32'd45);
      end
    end
    chk("ign_ndone", dn, 1);

    // back-to-back: start accepted in the DONE cycle
    issue(1, 0, 32'd3, 32'd4);
    wait_done("b2b1", n);
    chk("b2b1_lo", result_lo, 32'd12);
    issue(1, 0, 32'h0001_0000, 32'h0001_0000);
    chk("b2b_nogap", busy, 1);
    wait_done("b2b2", n);
    chk("b2b2_lat", n, 33);
    chk("b2b2_hi", result_hi, 32'd1);
    chk("b2b2_lo", result_lo, 32'd0);

    // asynchronous clear mid-operation
    issue(1, 1, 32'd123, 32'd456);
    repeat (15) @(posedge Clk);
    #2; Clear = 1'b1;
    #1;
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_lo", result_lo, 0);
    chk("clr_hi", result_hi, 0);
    @(negedge Clk); Clear = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (done) dn++;
    end
    chk("clr_nodone", dn, 0);
    issue(1, 0, 32'd6, 32'd7);
    wait_done("post_clr", n);
    chk("post_clr_lo", result_lo, 32'd42);
    chk("post_clr_hi", result_hi, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
